// File: rtl/ks_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder: the width legality
// check and the black/grey prefix cell functions.
package ks_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic bit legal_width(input int w);
    return (w == 4) || (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

  function automatic gp_t black_cell(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic logic grey_cell(input gp_t hi, input logic g_lo);
    return hi.g | (hi.p & g_lo);
  endfunction

endpackage

// File: rtl/ks_prefix_stage.sv
// One registered Kogge-Stone prefix level: positions below SPAN fold in the
// carry-in with a grey cell, the rest merge with the group SPAN bits lower.
module ks_prefix_stage
  import ks_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPAN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic             cin_i,
  input  logic [WIDTH-1:0] p_save_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] g_o,
  output logic             cin_o,
  output logic [WIDTH-1:0] p_save_o
);

  logic [WIDTH-1:0] p_d, g_d;
  logic [WIDTH-1:0] p_q, g_q, p_save_q;
  logic             cin_q, valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < SPAN) begin : g_grey
      assign g_d[i] = grey_cell(gp_t'{g: g_i[i], p: p_i[i]}, cin_i);
      assign p_d[i] = p_i[i];
    end else begin : g_black
      gp_t m;
      assign m      = black_cell(gp_t'{g: g_i[i], p: p_i[i]},
                                 gp_t'{g: g_i[i-SPAN], p: p_i[i-SPAN]});
      assign g_d[i] = m.g;
      assign p_d[i] = m.p;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    valid_q <= 1'b0;
    else if (en_i) valid_q <= valid_i;
  end

  // NOTE: datapath registers carry no reset; only the valid bit decides
  // whether their contents mean anything, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (en_i) begin
      p_q      <= p_d;
      g_q      <= g_d;
      cin_q    <= cin_i;
      p_save_q <= p_save_i;
    end
  end

  assign valid_o  = valid_q;
  assign p_o      = p_q;
  assign g_o      = g_q;
  assign cin_o    = cin_q;
  assign p_save_o = p_save_q;

endmodule

// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control; the
// whole pipe advances together on en, giving LEVELS+2 cycles of latency.
module ks_pipe_adder
  import ks_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c0,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c_out,
  output logic             o_ovf
);

  if (!legal_width(WIDTH)) begin : g_width_check
    $error("ks_pipe_adder: illegal WIDTH %0d (use 4, 8, 16, 32 or 64)", WIDTH);
  end

  logic en;
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  // Stage chain: index 0 is the operand stage, index k the k-th prefix level.
  logic             v_c   [LEVELS+1];
  logic [WIDTH-1:0] p_c   [LEVELS+1];
  logic [WIDTH-1:0] g_c   [LEVELS+1];
  logic [WIDTH-1:0] ps_c  [LEVELS+1];
  logic             cin_c [LEVELS+1];

  logic [WIDTH-1:0] b_eff;
  logic             s0_valid_q, s0_cin_q;
  logic [WIDTH-1:0] s0_p_q, s0_g_q, s0_psave_q;

  assign b_eff = i_sub ? ~i_b : i_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) s0_valid_q <= 1'b0;
    else if (en)  s0_valid_q <= i_valid;
  end

  always_ff @(posedge i_clk) begin
    if (en) begin
      s0_p_q     <= i_a ^ b_eff;
      s0_g_q     <= i_a & b_eff;
      s0_cin_q   <= i_c0 ^ i_sub;
      s0_psave_q <= i_a ^ b_eff;
    end
  end

  assign v_c[0]   = s0_valid_q;
  assign p_c[0]   = s0_p_q;
  assign g_c[0]   = s0_g_q;
  assign ps_c[0]  = s0_psave_q;
  assign cin_c[0] = s0_cin_q;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    ks_prefix_stage #(
      .WIDTH (WIDTH),
      .SPAN  (1 << (k - 1))
    ) u_stage (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .en_i     (en),
      .valid_i  (v_c[k-1]),
      .p_i      (p_c[k-1]),
      .g_i      (g_c[k-1]),
      .cin_i    (cin_c[k-1]),
      .p_save_i (ps_c[k-1]),
      .valid_o  (v_c[k]),
      .p_o      (p_c[k]),
      .g_o      (g_c[k]),
      .cin_o    (cin_c[k]),
      .p_save_o (ps_c[k])
    );
  end

  // carry[i] is the carry into bit i; the final grey row makes every group
  // include the carry-in, including those the last level only black-merged.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             valid_q, cout_q, ovf_q;
  logic [WIDTH-1:0] sum_q;

  // NOTE: the default assignment first keeps this block purely combinational.
  always_comb begin
    carry    = '0;
    carry[0] = cin_c[LEVELS];
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = grey_cell(gp_t'{g: g_c[LEVELS][i], p: p_c[LEVELS][i]},
                             cin_c[LEVELS]);
    end
  end

  assign sum_d = ps_c[LEVELS] ^ carry[WIDTH-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      valid_q <= v_c[LEVELS];
      sum_q   <= sum_d;
      cout_q  <= carry[WIDTH];
      ovf_q   <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_c_out = cout_q;
  assign o_ovf   = ovf_q;

endmodule

// File: doc/ks_pipe_adder.md
KS_PIPE_ADDER -- requirements
Module: ks_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width; legal values 4, 8, 16, 32, 64 (power of two).
REQ-002 Parameter LEVELS, default $clog2(WIDTH): derived prefix depth; not overridden by instantiators.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_valid  input  1  upstream operand word valid.
REQ-006 o_ready  output  1  block accepts an operand word this cycle.
REQ-007 i_a  input  WIDTH  operand A, two's complement or unsigned.
REQ-008 i_b  input  WIDTH  operand B.
REQ-009 i_c0  input  1  carry-in; borrow-in when i_sub=1.
REQ-010 i_sub  input  1  0 = add, 1 = subtract.
REQ-011 o_valid  output  1  result word valid.
REQ-012 i_ready  input  1  downstream accepts result this cycle.
REQ-013 o_sum  output  WIDTH  result.
REQ-014 o_c_out  output  1  carry-out of MSB (add: unsigned overflow; sub: 1 = no borrow).
REQ-015 o_ovf  output  1  signed overflow of the operation.

Function
REQ-016 Add: o_sum = i_a + i_b + i_c0 mod 2^WIDTH; o_c_out = bit WIDTH of the full sum.
REQ-017 Sub: B inverted bitwise, effective carry-in = ~i_c0; o_sum = i_a - i_b - i_c0 mod 2^WIDTH.
REQ-018 o_ovf = carry into MSB XOR carry out of MSB, for both modes.
REQ-019 Pipeline stage 0 registers bitwise p = a^b', g = a&b', effective carry-in, and p_save (original p for the sum stage).
REQ-020 Stages 1..LEVELS each register one Kogge-Stone prefix level at span 2^(k-1); positions below the span use a grey-cell merge with the carry-in, all others black-cell (p,g) merges.
REQ-021 Final stage registers o_sum = p_save ^ {carries[WIDTH-1:0]}, o_c_out, o_ovf.
REQ-022 Latency LEVELS+2 cycles from accepting handshake to o_valid with that result (WIDTH=16: 6 cycles).
REQ-023 Throughput one word per cycle while i_ready=1.
REQ-024 Word accepted when i_valid & o_ready; result retired when o_valid & i_ready.
REQ-025 Global advance enable en = ~o_valid | i_ready; all data and valid registers load only when en=1.
REQ-026 o_ready = en; combinational from i_ready and o_valid only, never from i_valid.
REQ-027 While stalled (o_valid=1, i_ready=0): o_sum, o_c_out, o_ovf, o_valid held stable; no word dropped or duplicated.
REQ-028 Bubbles (stage valid=0) propagate and are overwritten; a bubble never asserts o_valid.
REQ-029 Simultaneous accept and retire in one cycle is legal and sustains full throughput.
REQ-030 i_sub and i_c0 sampled with operands; mode may change every word.

Reset
REQ-031 i_rst_n=0 asynchronously clears all stage valid bits; o_valid=0, o_sum=0, o_c_out=0, o_ovf=0.
REQ-032 Reset mid-operation discards all in-flight words; none emerge after release.
REQ-033 Data registers other than outputs need no reset; valid bits must.
REQ-034 o_ready=1 during and immediately after reset.

Structure
REQ-035 Shared package ks_pkg holds legal-width check function and cell-level functions for black (g_hi|p_hi&g_lo, p_hi&p_lo) and grey (g_hi|p_hi&g_lo) merges.
REQ-036 One sub-module ks_prefix_stage (parameters WIDTH, SPAN): one prefix level plus its register and valid bit, instantiated LEVELS times by generate.
REQ-037 Elaboration error on illegal WIDTH.

Verification
REQ-038 WIDTH=16, add 0xFFFF+0x0001, c0=0 -> after 6 cycles o_sum=0x0000, o_c_out=1, o_ovf=0.
REQ-039 Add 0x7FFF+0x0001 -> o_sum=0x8000, o_c_out=0, o_ovf=1; sub 0x0005-0x0007 -> o_sum=0xFFFE, o_c_out=0, o_ovf=0.
REQ-040 Back-to-back 100 random words, i_ready=1 -> 100 results in order, one per cycle, matching reference model.
REQ-041 Random i_ready (50%) with i_valid=1 -> no loss/duplication, outputs stable during every stall, o_ready=0 exactly when o_valid=1 and i_ready=0.
REQ-042 Assert i_rst_n=0 with 4 words in flight -> o_valid=0 immediately, no stale result after release.
REQ-043 Repeat REQ-038 and REQ-040 at WIDTH=4, 32 and 64 (latency 4, 7, 8).
